// File: rtl/vlb_reg_slave.sv
// vlb_reg_slave
//   Three-register slave behind a valid/ready request/response port.
//   Registers:
//     VOL_ADDR  : 32-bit volatile counter, host RW, decremented by hw_dec while
//                 ctrl.en is set, saturating at 0.
//     DATA_ADDR : plain 32-bit RW register, mirrored on data_out.
//     CTRL_ADDR : bit0 en (RW), bit1 irq_en (RW), bit2 reload (write-1 action,
//                 reads 0), bit8 zero (sticky, W1C). Other bits read 0.
//
//   Handshake: a channel transfers on the rising edge where valid && ready are
//   both 1. The host keeps valid and its payload stable until that edge; the
//   slave holds rsp_valid/rsp_rdata/rsp_err stable until rsp_ready is seen.
//
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     req_valid/ready/write/addr/wdata   request channel
//     rsp_valid/ready/rdata/err  response channel (err = unmapped address)
//     hw_dec                     hardware decrement pulse for the volatile reg
//     data_out                   current data register value
//     irq                        ctrl.irq_en & ctrl.zero
//     dbg_state                  current FSM state (IDLE=0, ACCESS=1, RESP=2)
module vlb_reg_slave #(
    parameter logic [31:0] VOL_RST_VAL = 32'd44,
    parameter logic [31:0] VOL_ADDR    = 32'h0000_0004,
    parameter logic [31:0] DATA_ADDR   = 32'h0000_0008,
    parameter logic [31:0] CTRL_ADDR   = 32'h0000_000c
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        hw_dec,
    output logic [31:0] data_out,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] vol_q, vol_d;
    logic [31:0] data_q, data_d;
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        zero_q, zero_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        vol_hit, data_hit, ctrl_hit;
    logic        do_write, vol_load, dec_fire, zero_set;
    logic [31:0] ctrl_word;

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        vol_d    = vol_q;
        data_d   = data_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        zero_d   = zero_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        // Full 32-bit compare: misaligned addresses simply miss every register.
        vol_hit   = (addr_q == VOL_ADDR);
        data_hit  = (addr_q == DATA_ADDR);
        ctrl_hit  = (addr_q == CTRL_ADDR);
        ctrl_word = {23'd0, zero_q, 5'd0, 1'b0, irq_en_q, en_q};
        do_write  = (state_q == ST_ACCESS) && wr_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Read data is the register value before this cycle's update.
                rdata_d = 32'd0;
                err_d   = !(vol_hit || data_hit || ctrl_hit);
                if (!wr_q) begin
                    if (vol_hit)       rdata_d = vol_q;
                    else if (data_hit) rdata_d = data_q;
                    else if (ctrl_hit) rdata_d = ctrl_word;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A host load (direct write or reload) overrides a same-cycle decrement.
        vol_load = do_write && (vol_hit || (ctrl_hit && wdata_q[2]));
        dec_fire = en_q && hw_dec && (vol_q != 32'd0);
        zero_set = dec_fire && !vol_load && (vol_q == 32'd1);

        if (vol_load) begin
            vol_d = vol_hit ? wdata_q : VOL_RST_VAL;
        end else if (dec_fire) begin
            vol_d = vol_q - 32'd1;
        end

        if (do_write && data_hit) begin
            data_d = wdata_q;
        end

        if (do_write && ctrl_hit) begin
            en_d     = wdata_q[0];
            irq_en_d = wdata_q[1];
            if (wdata_q[8]) zero_d = 1'b0;
        end

        // Set beats a coincident W1C clear.
        if (zero_set) begin
            zero_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            vol_q    <= VOL_RST_VAL;
            data_q   <= 32'd0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            zero_q   <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            vol_q    <= vol_d;
            data_q   <= data_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            zero_q   <= zero_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign data_out  = data_q;
    assign irq       = irq_en_q && zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vlb_reg_slave.sv
module tb_vlb_reg_slave;

    localparam logic [31:0] VOL_A  = 32'h0000_0004;
    localparam logic [31:0] DATA_A = 32'h0000_0008;
    localparam logic [31:0] CTRL_A = 32'h0000_000c;
    localparam logic [31:0] VOL_RV = 32'd44;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        hw_dec;
    logic [31:0] data_out;
    logic        irq;
    logic [1:0]  dbg_state;

    vlb_reg_slave dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .hw_dec    (hw_dec),
        .data_out  (data_out),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: register contents as the host sees them
    logic [31:0] m_vol;
    logic [31:0] m_data;
    logic        m_en;
    logic        m_irq_en;
    logic        m_zero;

    logic [31:0] exp_q[$];
    int          n_vec;
    int          n_err;

    function automatic logic [31:0] m_ctrl();
        return {23'd0, m_zero, 5'd0, 1'b0, m_irq_en, m_en};
    endfunction

    function automatic logic m_mapped(input logic [31:0] a);
        return (a == VOL_A) || (a == DATA_A) || (a == CTRL_A);
    endfunction

    task automatic m_reset();
        m_vol    = VOL_RV;
        m_data   = 32'd0;
        m_en     = 1'b0;
        m_irq_en = 1'b0;
        m_zero   = 1'b0;
    endtask

    // One clock edge of register behaviour: optional host write plus hw_dec.
    task automatic m_tick(input logic dec, input logic wr, input logic [31:0] a,
                          input logic [31:0] d);
        logic loaded;
        logic dec_ok;
        dec_ok = dec && m_en && (m_vol != 0);
        loaded = wr && ((a == VOL_A) || (a == CTRL_A && d[2]));
        if (loaded) begin
            m_vol = (a == VOL_A) ? d : VOL_RV;
        end else if (dec_ok) begin
            if (m_vol == 1) m_zero = 1'b1;
            m_vol = m_vol - 1;
        end
        if (wr && a == DATA_A) m_data = d;
        if (wr && a == CTRL_A) begin
            m_en     = d[0];
            m_irq_en = d[1];
            if (d[8] && !(dec_ok && !loaded && m_zero && m_vol == 0 && !d[8])) begin
                // W1C unless this same edge produced the zero event
                if (!(dec_ok && !loaded && m_vol == 0 && m_zero)) m_zero = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".data_out"}, data_out, m_data);
        chk({tag, ".irq"}, {31'd0, irq}, {31'd0, m_irq_en & m_zero});
    endtask

    // driver: one full request/response transaction
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic dec_acc, input int hold, input logic rnd_dec);
        logic [31:0] exp_rd;
        logic        exp_err;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        hw_dec    = 1'b0;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);                           // accept edge
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        chk("rsp_valid_access", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_access", {31'd0, req_ready}, 32'd0);
        hw_dec = dec_acc;
        exp_err = !m_mapped(a);
        exp_rd  = 32'd0;
        if (!w && a == VOL_A)  exp_rd = m_vol;
        if (!w && a == DATA_A) exp_rd = m_data;
        if (!w && a == CTRL_A) exp_rd = m_ctrl();
        exp_q.push_back({31'd0, exp_err});
        exp_q.push_back(exp_rd);
        @(posedge clk);                           // access edge
        m_tick(dec_acc, w, a, d);
        @(negedge clk);
        hw_dec = 1'b0;
        chk("rsp_valid_lat2", {31'd0, rsp_valid}, 32'd1);
        exp_err = exp_q.pop_front();
        exp_rd  = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        chk_outs("resp");
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;                     // next request waiting; must not be taken
            req_addr  = DATA_A;
            req_write = 1'b1;
            hw_dec    = rnd_dec ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            m_tick(hw_dec, 1'b0, 32'd0, 32'd0);
            @(negedge clk);
            hw_dec = 1'b0;
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", {31'd0, rsp_err}, {31'd0, exp_err});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_done", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_done", {31'd0, req_ready}, 32'd1);
    endtask

    // idle cycles with hw_dec pulses (every cycle, or random)
    task automatic idle(input int n, input logic rnd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hw_dec = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            m_tick(hw_dec, 1'b0, 32'd0, 32'd0);
        end
        @(negedge clk);
        hw_dec = 1'b0;
        chk_outs("idle");
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        hw_dec    = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk_outs("rst");

        // reset values readable
        do_req(1'b0, VOL_A, 32'd0, 1'b0, 0, 1'b0);
        do_req(1'b0, CTRL_A, 32'd0, 1'b0, 0, 1'b0);

        // data register
        do_req(1'b1, DATA_A, 32'hA5A5_5A5A, 1'b0, 0, 1'b0);
        do_req(1'b0, DATA_A, 32'd0, 1'b0, 0, 1'b0);

        // decrement to saturation, sticky zero, irq, W1C
        do_req(1'b1, CTRL_A, 32'h3, 1'b0, 0, 1'b0);
        do_req(1'b1, VOL_A, 32'd2, 1'b0, 0, 1'b0);
        idle(3, 1'b0);
        do_req(1'b0, VOL_A, 32'd0, 1'b0, 0, 1'b0);
        do_req(1'b0, CTRL_A, 32'd0, 1'b0, 0, 1'b0);
        do_req(1'b1, CTRL_A, 32'h103, 1'b0, 0, 1'b0);
        do_req(1'b0, CTRL_A, 32'd0, 1'b0, 0, 1'b0);

        // reload, then host write coincident with hw_dec
        do_req(1'b1, CTRL_A, 32'h5, 1'b0, 0, 1'b0);
        do_req(1'b0, VOL_A, 32'd0, 1'b0, 0, 1'b0);
        do_req(1'b0, CTRL_A, 32'd0, 1'b0, 0, 1'b0);
        do_req(1'b1, VOL_A, 32'd10, 1'b1, 0, 1'b0);
        do_req(1'b0, VOL_A, 32'd0, 1'b0, 0, 1'b0);

        // zero set and W1C on the same edge: set wins
        do_req(1'b1, VOL_A, 32'd1, 1'b0, 0, 1'b0);
        do_req(1'b1, CTRL_A, 32'h103, 1'b1, 0, 1'b0);
        do_req(1'b0, CTRL_A, 32'd0, 1'b0, 0, 1'b0);

        // unmapped / misaligned, long back-pressure
        do_req(1'b0, 32'h0, 32'd0, 1'b0, 5, 1'b0);
        do_req(1'b0, 32'h10, 32'd0, 1'b0, 2, 1'b0);
        do_req(1'b0, 32'h6, 32'd0, 1'b0, 0, 1'b0);
        do_req(1'b1, 32'h6, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        do_req(1'b0, DATA_A, 32'd0, 1'b0, 0, 1'b0);
        do_req(1'b0, VOL_A, 32'd0, 1'b0, 0, 1'b0);

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a = VOL_A;
                1: a = DATA_A;
                2: a = CTRL_A;
                3: a = 32'h0;
                4: a = {$urandom_range(1, 255), 8'h00} | 32'h4;
                default: a = VOL_A + 32'd1;
            endcase
            d = (a == VOL_A) ? 32'($urandom_range(0, 3)) : $urandom;
            do_req(w, a, d, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
            idle($urandom_range(0, 3), 1'b1);
        end

        // reset while the response of a data write is pending
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = DATA_A;
        req_wdata = 32'd7;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        m_tick(1'b0, 1'b1, DATA_A, 32'd7);
        @(negedge clk);
        chk("pre_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk_outs("abort");
        do_req(1'b0, VOL_A, 32'd0, 1'b0, 0, 1'b0);
        do_req(1'b0, DATA_A, 32'd0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vlb_reg_slave.md
VLB_REG_SLAVE -- requirements
Module: vlb_reg_slave

Interface
REQ-001 The block SHALL have parameter VOL_RST_VAL, default 44, the reset and reload value of the volatile register.
REQ-002 The block SHALL have parameter VOL_ADDR, default 32'h00000004, the volatile register address.
REQ-003 The block SHALL have parameter DATA_ADDR, default 32'h00000008, the data register address.
REQ-004 The block SHALL have parameter CTRL_ADDR, default 32'h0000000c, the control register address.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, the reset, which is synchronous and active-low.
REQ-007 The block SHALL have port req_valid, input, 1 bit, meaning a host request is present.
REQ-008 The block SHALL have port req_ready, output, 1 bit, meaning the block can accept a request.
REQ-009 The block SHALL have port req_write, input, 1 bit, where 1 is a write and 0 is a read.
REQ-010 The block SHALL have port req_addr, input, 32 bits, the byte address.
REQ-011 The block SHALL have port req_wdata, input, 32 bits, the write data.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit, meaning a response is present.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit, meaning the host accepts the response.
REQ-014 The block SHALL have port rsp_rdata, output, 32 bits, the read data (0 for writes).
REQ-015 The block SHALL have port rsp_err, output, 1 bit, flagging an unmapped address.
REQ-016 The block SHALL have port hw_dec, input, 1 bit, a hardware decrement pulse for the volatile register.
REQ-017 The block SHALL have port data_out, output, 32 bits, the current data register value.
REQ-018 The block SHALL have port irq, output, 1 bit, which equals ctrl.irq_en AND ctrl.zero.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and RESP, with req_ready=1 only in IDLE.
REQ-020 On req_valid&&req_ready the block SHALL capture write/addr/wdata and go IDLE->ACCESS.
REQ-021 In ACCESS (exactly 1 cycle) the block SHALL decode the full 32-bit address, perform the write or sample the read data, then go to RESP.
REQ-022 In RESP, rsp_valid=1 with rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1, then the FSM returns to IDLE.
REQ-023 Latency: rsp_valid SHALL rise 2 cycles after the accept edge; minimum throughput is one request per 3 cycles.
REQ-024 The volatile register SHALL be 32 bits, read/write; the host write loads req_wdata.
REQ-025 When ctrl.en (bit0)=1 and hw_dec=1 and the volatile register is non-zero, the volatile register SHALL decrement by 1.
REQ-026 The volatile register SHALL saturate at 0 and never wrap.
REQ-027 On a 1->0 decrement of the volatile register, ctrl.zero (bit8) SHALL be set; the bit is sticky.
REQ-028 If a host write to the volatile register or a reload and hw_dec occur in the same cycle, the host write/reload SHALL win and the decrement is dropped.
REQ-029 The data register SHALL be a plain 32-bit read/write register, and data_out SHALL update the cycle after the ACCESS write.
REQ-030 The ctrl register SHALL have bit0 en (RW), bit1 irq_en (RW), bit2 reload (write 1 loads VOL_RST_VAL into the volatile register and leaves ctrl.zero unchanged; reads 0), and bit8 zero (W1C; writing 0 has no effect).
REQ-031 All other ctrl bits SHALL read 0.
REQ-032 If a zero-set event and a W1C of ctrl.zero occur in the same cycle, the set SHALL win.
REQ-033 An unmapped or misaligned address SHALL produce rsp_err=1 and rsp_rdata=0, with no state change.
REQ-034 req_valid while not in IDLE SHALL be ignored (not captured), with the host holding the request per valid/ready rules.

Reset
REQ-035 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-036 While rst_n=0 at a clock edge, the volatile register SHALL be set to VOL_RST_VAL (44) and the data register and ctrl SHALL be set to 0.
REQ-037 While rst_n=0 at a clock edge, req_ready SHALL be 1 after reset, and rsp_valid, rsp_rdata, rsp_err, data_out and irq SHALL be 0.
REQ-038 A reset mid-transaction (ACCESS or RESP) SHALL abort it with no response issued; if the abort is in ACCESS, the pending write is discarded.

Verification
REQ-039 Reset then read 0x4 -> rsp_valid 2 cycles after accept, rdata=44, err=0; read 0xc -> rdata=0.
REQ-040 Write 0x8=0xA5A5_5A5A then read 0x8 -> data_out=0xA5A5_5A5A one cycle after ACCESS, and the read returns the same value.
REQ-041 Write ctrl=0x3, write vol=2, then 3 hw_dec pulses -> vol=0 (saturated), ctrl reads 0x103, irq=1; write ctrl=0x103 (W1C) -> zero=0, irq=0.
REQ-042 Write ctrl=0x5 -> vol=44, ctrl reads 0x1; a host vol write of 10 coincident with hw_dec -> vol=10.
REQ-043 Read 0x0, 0x10 and 0x6 -> err=1, rdata=0, all registers unchanged; hold rsp_ready=0 for 5 cycles -> response stable and req_ready=0 throughout.
REQ-044 Assert rst_n=0 during RESP after a write of 0x8=7 -> no response, data=0, vol=44, req_ready=1.
